adder_serial: RTL and testbench
===============================

// Module: adder_serial
// PURPOSE
//   Digit-serial N-bit adder: adds two N-bit operands K bits per clock, LSB slice first,
//   through one shared K-bit adder slice with a registered carry.
//   Sequential, area-reduced successor to the combinational N-bit adder (a + b -> s, c).
//   Adds carry-in, start/busy/done handshake and an optional signed-overflow flag.
//   Sits on datapaths where latency is traded for adder width.
// PARAMETERS
//   N       6   operand/sum width in bits; N >= 1
//   K       2   bits processed per cycle; 1 <= K <= N; N % K == 0 (else $error at elaboration)
//   SIGNED  0   1: ovf reports two's-complement overflow; 0: ovf tied 0
// PORTS
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous, active-high reset
//   start  in   1   request; sampled only in IDLE or DONE
//   a      in   N   operand A; captured on accepted start
//   b      in   N   operand B; captured on accepted start
//   cin    in   1   carry-in; captured on accepted start
//   busy   out  1   high while slices are being processed
//   done   out  1   one-cycle pulse; s/c/ovf valid from this cycle
//   s      out  N   sum, (a + b + cin) mod 2^N
//   c      out  1   carry-out of bit N-1
//   ovf    out  1   SIGNED=1: operand sign bits equal and sum sign differs
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, s=0, c=0, ovf=0; slice counter=0.
//   States:
//     IDLE: start=1 -> latch a, b; carry reg = cin; count=0; go to BUSY.
//     BUSY: busy=1. Each cycle computes {cy, sum_k} = a[k] + b[k] + carry,
//           where slice k = bits [count*K +: K].
//           sum_k is written into s[count*K +: K]; carry reg = cy; count++.
//           Last slice (count == N/K-1) -> go to DONE.
//     DONE: done=1 for exactly one cycle; c = final carry; ovf computed; busy=0.
//           start=1 -> accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
//   Latency: start accepted at edge t; busy for N/K cycles; done high in the cycle
//     after edge t+N/K. Throughput: one add per N/K+1 cycles.
//   s, c, ovf hold their final values until the next accepted start.
//   On the next accepted start they are NOT cleared; slices overwrite s as they are computed.
//   s and c are stable and valid only while done=1 and afterwards until the next start.
//   start while BUSY is ignored. Latched operands are unaffected by a/b changes after capture.
//   Widths: slice add is K+1 bits wide; no truncation beyond N; count width = clog2(N/K), min 1.
//   K == N: single BUSY cycle; done follows one cycle after acceptance.
//   rst asserted mid-operation: aborts at the next edge; all outputs return to reset
//     values; no done pulse is issued for the aborted add.
//   rst has priority over start on the same edge.
//   X/Z on a, b or cin propagates to s/c in simulation. No masking is required.
// TESTING (N=6, K=2 unless noted)
//   T1: a=5, b=7, cin=0, start pulse -> busy 3 cycles, then done;
//       s=6'b001100, c=0, ovf=0.
//   T2: a=63, b=1, cin=0 -> s=0, c=1. Then a=0, b=15, cin=1 -> s=16, c=0.
//   T3: SIGNED=1: a=31, b=1 -> s=6'b100000, ovf=1, c=0.
//       a=-1 (63), b=-1 -> s=62, c=1, ovf=0.
//   T4: start re-pulsed mid-BUSY with different operands -> ignored; result matches T1.
//       start high during done cycle -> new add accepted, busy the next cycle.
//   T5: rst pulsed in 2nd BUSY cycle -> next cycle busy=0, s=0, c=0; no done pulse.
//       A subsequent start completes correctly.
//   T6: N=8, K=8 and N=8, K=1 -> a=200, b=100 gives s=44, c=1.
//       Done 1 and 8 cycles after busy rises, respectively.
//       Random self-check of 1000 vectors against a + b + cin.

Source files
------------

// File: rtl/adder_serial.sv
// adder_serial: digit-serial N-bit adder, K bits per clock, LSB slice first, registered carry
module adder_serial #(
   parameter int N      = 6,
   parameter int K      = 2,
   parameter bit SIGNED = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s,
   output logic         c,
   output logic         ovf
);
   localparam int S  = N / K;
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        r_state, w_next;
   logic [N-1:0]  r_a, r_b, r_s;
   logic          r_carry, r_c, r_ovf;
   logic [CW-1:0] r_cnt;
   logic          w_acc, w_last;
   logic [K:0]    w_slice;

   if (K < 1 || K > N || N % K != 0) begin : g_chk
      $error("adder_serial: K must divide N with 1 <= K <= N");
   end

   assign w_acc   = (r_state != BUSY) && start;
   assign w_last  = r_cnt == CW'(S - 1);
   assign w_slice = {1'b0, r_a[r_cnt*K +: K]} + {1'b0, r_b[r_cnt*K +: K]} + (K+1)'(r_carry);

   always_comb begin
      w_next = w_acc ? BUSY : (r_state == DONE) ? IDLE : (r_state == BUSY && w_last) ? DONE : r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_c     <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_acc) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == BUSY) begin
         r_s[r_cnt*K +: K] <= w_slice[K-1:0];
         r_carry           <= w_slice[K];
         r_cnt             <= r_cnt + 1'b1;
         // the last slice holds bit N-1, so its sum MSB is the result sign
         if (w_last) begin
            r_c   <= w_slice[K];
            r_ovf <= SIGNED && (r_a[N-1] == r_b[N-1]) && (w_slice[K-1] != r_a[N-1]);
         end
      end
   end

   assign busy = r_state == BUSY;
   assign done = r_state == DONE;
   assign s    = r_s;
   assign c    = r_c;
   assign ovf  = r_ovf;
endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: directed and random checks of adder_serial in four parameterisations
module tb_adder_serial;
   logic clk = 1'b0, rst = 1'b1;
   int   n_tests = 0, n_fail = 0;

   logic       st0 = 0, ci0 = 0, bz0, dn0, c0, o0;
   logic [5:0] a0 = 0, b0 = 0, s0;
   logic       st1 = 0, ci1 = 0, bz1, dn1, c1, o1;
   logic [5:0] a1 = 0, b1 = 0, s1;
   logic       st2 = 0, ci2 = 0, bz2, dn2, c2, o2;
   logic [7:0] a2 = 0, b2 = 0, s2;
   logic       st3 = 0, ci3 = 0, bz3, dn3, c3, o3;
   logic [7:0] a3 = 0, b3 = 0, s3;

   always #5 clk = ~clk;

   adder_serial #(.N(6), .K(2), .SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .cin(ci0),
      .busy(bz0), .done(dn0), .s(s0), .c(c0), .ovf(o0));
   adder_serial #(.N(6), .K(2), .SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
      .busy(bz1), .done(dn1), .s(s1), .c(c1), .ovf(o1));
   adder_serial #(.N(8), .K(8), .SIGNED(1'b0)) u2 (.clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(ci2),
      .busy(bz2), .done(dn2), .s(s2), .c(c2), .ovf(o2));
   adder_serial #(.N(8), .K(1), .SIGNED(1'b0)) u3 (.clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .cin(ci3),
      .busy(bz3), .done(dn3), .s(s3), .c(c3), .ovf(o3));

   // each op task starts at #1 after an edge and returns at the first sample with done high
   task automatic op0(input logic [5:0] a, input logic [5:0] b, input logic ci, output int cyc, output int nb);
      a0 = a; b0 = b; ci0 = ci; st0 = 1;
      @(posedge clk); #1; st0 = 0;
      cyc = 0; nb = 0;
      while (!dn0 && cyc < 50) begin nb += int'(bz0); @(posedge clk); #1; cyc++; end
   endtask

   task automatic op1(input logic [5:0] a, input logic [5:0] b, input logic ci, output int cyc);
      a1 = a; b1 = b; ci1 = ci; st1 = 1;
      @(posedge clk); #1; st1 = 0;
      cyc = 0;
      while (!dn1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic ci, output int cyc);
      a2 = a; b2 = b; ci2 = ci; st2 = 1;
      @(posedge clk); #1; st2 = 0;
      cyc = 0;
      while (!dn2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic op3(input logic [7:0] a, input logic [7:0] b, input logic ci, output int cyc);
      a3 = a; b3 = b; ci3 = ci; st3 = 1;
      @(posedge clk); #1; st3 = 0;
      cyc = 0;
      while (!dn3 && cyc < 50) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({bz0, dn0, s0, c0, o0} !== 9'b0 || {bz1, dn1, s1, c1, o1} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset u0 bdsco=%b%b %0d %b%b u1 bdsco=%b%b %0d %b%b want all 0",
            bz0, dn0, s0, c0, o0, bz1, dn1, s1, c1, o1);
      end
      n_tests++;
      if ({bz2, dn2, s2, c2, bz3, dn3, s3, c3} !== 22'b0) begin
         n_fail++;
         $display("FAIL reset_n8 u2 s=%0d c=%b u3 s=%0d c=%b want 0", s2, c2, s3, c3);
      end
      rst = 0;
   endtask

   task automatic test_basic;
      int cyc, nb;
      op0(6'd5, 6'd7, 1'b0, cyc, nb);
      n_tests++;
      if (cyc != 3 || nb != 3) begin n_fail++; $display("FAIL t1_latency cyc=%0d busy=%0d want 3 3", cyc, nb); end
      n_tests++;
      if ({s0, c0, o0, bz0} !== {6'b001100, 3'b000}) begin
         n_fail++; $display("FAIL t1_result s=%b c=%b ovf=%b busy=%b want 001100 0 0 0", s0, c0, o0, bz0);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({dn0, bz0, s0, c0} !== {2'b00, 6'd12, 1'b0}) begin
         n_fail++; $display("FAIL t1_hold done=%b busy=%b s=%0d c=%b want 0 0 12 0", dn0, bz0, s0, c0);
      end
      op0(6'd63, 6'd1, 1'b0, cyc, nb);
      n_tests++;
      if ({s0, c0} !== {6'd0, 1'b1} || cyc != 3) begin
         n_fail++; $display("FAIL t2_wrap s=%0d c=%b cyc=%0d want 0 1 3", s0, c0, cyc);
      end
      @(posedge clk); #1;
      op0(6'd0, 6'd15, 1'b1, cyc, nb);
      n_tests++;
      if ({s0, c0} !== {6'd16, 1'b0}) begin n_fail++; $display("FAIL t2_cin s=%0d c=%b want 16 0", s0, c0); end
      @(posedge clk); #1;
   endtask

   task automatic test_signed;
      int cyc;
      op1(6'd31, 6'd1, 1'b0, cyc);
      n_tests++;
      if ({s1, c1, o1} !== {6'b100000, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL t3_pos_ovf s=%b c=%b ovf=%b want 100000 0 1", s1, c1, o1);
      end
      @(posedge clk); #1;
      op1(6'd63, 6'd63, 1'b0, cyc);
      n_tests++;
      if ({s1, c1, o1} !== {6'd62, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL t3_neg s=%0d c=%b ovf=%b want 62 1 0", s1, c1, o1);
      end
      @(posedge clk); #1;
      op1(6'd32, 6'd32, 1'b0, cyc);
      n_tests++;
      if ({s1, c1, o1} !== {6'd0, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL t3_neg_ovf s=%0d c=%b ovf=%b want 0 1 1", s1, c1, o1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int cyc, nb;
      a0 = 6'd5; b0 = 6'd7; ci0 = 0; st0 = 1;
      @(posedge clk); #1; st0 = 0;
      @(posedge clk); #1;
      a0 = 6'd20; b0 = 6'd20; ci0 = 1; st0 = 1;
      @(posedge clk); #1; st0 = 0;
      cyc = 0;
      while (!dn0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      n_tests++;
      if ({s0, c0} !== {6'd12, 1'b0} || cyc != 1) begin
         n_fail++; $display("FAIL t4_ignore s=%0d c=%b cyc=%0d want 12 0 1", s0, c0, cyc);
      end
      a0 = 6'd1; b0 = 6'd2; ci0 = 0; st0 = 1;
      @(posedge clk); #1; st0 = 0;
      n_tests++;
      if ({bz0, dn0} !== 2'b10) begin n_fail++; $display("FAIL t4_b2b_busy busy=%b done=%b want 1 0", bz0, dn0); end
      cyc = 0;
      while (!dn0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      n_tests++;
      if ({s0, c0} !== {6'd3, 1'b0} || cyc != 3) begin
         n_fail++; $display("FAIL t4_b2b_result s=%0d c=%b cyc=%0d want 3 0 3", s0, c0, cyc);
      end
      @(posedge clk); #1;
      op0(6'd9, 6'd9, 1'b0, cyc, nb);
      n_tests++;
      if (nb != 3 || s0 !== 6'd18) begin n_fail++; $display("FAIL t4_nb busy=%0d s=%0d want 3 18", nb, s0); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort;
      int cyc, nb;
      bit seen;
      a0 = 6'd5; b0 = 6'd7; ci0 = 0; st0 = 1;
      @(posedge clk); #1; st0 = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      n_tests++;
      if ({bz0, dn0, s0, c0, o0} !== 10'b0) begin
         n_fail++; $display("FAIL t5_abort busy=%b done=%b s=%0d c=%b ovf=%b want 0 0 0 0 0", bz0, dn0, s0, c0, o0);
      end
      seen = 0;
      repeat (6) begin seen |= dn0 | bz0; @(posedge clk); #1; end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL t5_no_done saw done/busy=%b want 0", seen); end
      op0(6'd10, 6'd20, 1'b0, cyc, nb);
      n_tests++;
      if ({s0, c0} !== {6'd30, 1'b0} || cyc != 3) begin
         n_fail++; $display("FAIL t5_after s=%0d c=%b cyc=%0d want 30 0 3", s0, c0, cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_widths;
      int cyc;
      op2(8'd200, 8'd100, 1'b0, cyc);
      n_tests++;
      if ({s2, c2} !== {8'd44, 1'b1} || cyc != 1) begin
         n_fail++; $display("FAIL t6_k8 s=%0d c=%b cyc=%0d want 44 1 1", s2, c2, cyc);
      end
      op3(8'd200, 8'd100, 1'b0, cyc);
      n_tests++;
      if ({s3, c3} !== {8'd44, 1'b1} || cyc != 8) begin
         n_fail++; $display("FAIL t6_k1 s=%0d c=%b cyc=%0d want 44 1 8", s3, c3, cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int cyc, nb;
      logic [7:0] ra, rb;
      logic       rc, eo;
      logic [8:0] e;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         e  = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         op3(ra, rb, rc, cyc);
         n_tests++;
         if ({c3, s3, o3} !== {e, 1'b0} || cyc != 8) begin
            n_fail++; $display("FAIL rand_k1 %0d+%0d+%0d got c=%b s=%0d cyc=%0d want %0d", ra, rb, rc, c3, s3, cyc, e);
         end
      end
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         e  = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         op2(ra, rb, rc, cyc);
         n_tests++;
         if ({c2, s2} !== e || cyc != 1) begin
            n_fail++; $display("FAIL rand_k8 %0d+%0d+%0d got c=%b s=%0d cyc=%0d want %0d", ra, rb, rc, c2, s2, cyc, e);
         end
      end
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 63)); rb = 8'($urandom_range(0, 63)); rc = 1'($urandom);
         e  = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         eo = (ra[5] == rb[5]) && (e[5] != ra[5]);
         op1(ra[5:0], rb[5:0], rc, cyc);
         n_tests++;
         if ({c1, s1, o1} !== {e[6:0], eo}) begin
            n_fail++; $display("FAIL rand_signed %0d+%0d+%0d got c=%b s=%0d ovf=%b want %0d ovf=%b", ra, rb, rc, c1, s1, o1, e[6:0], eo);
         end
         op0(ra[5:0], rb[5:0], rc, cyc, nb);
         n_tests++;
         if ({c0, s0, o0} !== {e[6:0], 1'b0} || cyc != 3) begin
            n_fail++; $display("FAIL rand_unsigned %0d+%0d+%0d got c=%b s=%0d ovf=%b cyc=%0d want %0d", ra, rb, rc, c0, s0, o0, cyc, e[6:0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_back_to_back;
      test_abort;
      test_widths;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
